// File: rtl/mips_mem_loader.sv
// mips_mem_loader: loads header+payload segments into core memory, runs the core, dumps a memory window.
// Optional MIPS_LOADER_WDOG_EN: RUN-state watchdog that forces the dump after WDOG_CYCLES.
module mips_mem_loader #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_hold,
  output logic          cpu_start,
  input  logic          cpu_halted,
  input  logic [AW-1:0] dump_base,
  input  logic [15:0]   dump_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic          error
);
  typedef enum logic [2:0] {HDR, DATA, START, RUN, DUMP, DONE} st_t;
  st_t state, nxt;
  logic [15:0] count, rd_left, out_left;
  logic [AW-1:0] addr, wa, rd_ptr, pa;
  logic acc, pend, to, ovf, unused_ok;
  assign acc = in_valid & in_ready;
  assign ovf = in_data[31:16] != 16'd0 &&
               (32'(in_data[AW-1:0]) + 32'(in_data[31:16])) > (32'd1 << AW);
  assign mem_re = state == DUMP && rd_left != 16'd0 && !pend && (!out_valid || out_ready);
  assign mem_addr = mem_re ? rd_ptr : wa;
  assign unused_ok = ^{in_data[15:AW], WDOG_CYCLES};
`ifdef MIPS_LOADER_WDOG_EN
  logic [31:0] wd;
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) wd <= '0;
    else if (state == START) wd <= 32'd1;
    else if (state == RUN) wd <= wd + 32'd1;
  assign to = state == RUN && wd == 32'(WDOG_CYCLES - 1);
`else
  assign to = 1'b0;
`endif
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) state <= HDR;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      HDR:   if (acc) nxt = in_data[31:16] == 16'd0 ? START : DATA;
      DATA:  if (acc && count == 16'd1) nxt = HDR;
      START: nxt = RUN;
      RUN:   if (cpu_halted || to) nxt = dump_len == 16'd0 ? DONE : DUMP;
      DUMP:  if (out_valid && out_ready && out_left == 16'd1) nxt = DONE;
      default: nxt = state;
    endcase
  end
  // Control outputs are registered from the next state so reset values hold exactly.
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      in_ready  <= 1'b0;
      cpu_start <= 1'b0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_ready  <= nxt == HDR || nxt == DATA;
      cpu_start <= nxt == START;
      cpu_hold  <= !(nxt == START || nxt == RUN);
      busy      <= nxt != DONE && (nxt != HDR || busy);
      done      <= nxt == DONE;
    end
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      count     <= '0;
      addr      <= '0;
      wa        <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      error     <= 1'b0;
      rd_ptr    <= '0;
      rd_left   <= '0;
      out_left  <= '0;
      pend      <= 1'b0;
      pa        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      mem_we <= state == DATA && acc;
      if (state == HDR && acc) begin
        count <= in_data[31:16];
        addr  <= in_data[AW-1:0];
        if (ovf) error <= 1'b1;
      end
      if (state == DATA && acc) begin
        wa        <= addr;
        mem_wdata <= in_data;
        addr      <= addr + 1'b1;
        count     <= count - 16'd1;
      end
      if (to) error <= 1'b1;
      if (state == RUN) begin
        rd_ptr   <= dump_base;
        rd_left  <= dump_len;
        out_left <= dump_len;
      end
      pend <= mem_re;
      if (mem_re) begin
        pa      <= rd_ptr;
        rd_ptr  <= rd_ptr + 1'b1;
        rd_left <= rd_left - 16'd1;
      end
      out_valid <= pend || (out_valid && !out_ready);
      if (pend) begin
        out_data <= mem_rdata;
        out_addr <= pa;
      end
      if (out_valid && out_ready) out_left <= out_left - 16'd1;
    end
endmodule

// File: tb/tb_mips_mem_loader.sv
// tb_mips_mem_loader: directed checks of load, run, dump, stall, wrap, reset and watchdog behaviour.
module tb_mips_mem_loader;
  localparam int AW = 10, DW = 32, WD = 64;
  localparam logic [31:0] PROG [8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                                       32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
  logic clk1 = 0, rst_n = 1;
  logic in_valid = 0, in_ready, mem_we, mem_re, cpu_hold, cpu_start, halted = 0;
  logic out_valid, out_ready = 1, busy, done, error;
  logic [DW-1:0] in_data = 0, mem_wdata, rdata, out_data;
  logic [AW-1:0] mem_addr, dump_base = 10'd120, out_addr;
  logic [15:0] dump_len = 16'd2;
  logic [31:0] mem [1024];
  logic [AW-1:0] wlog [16], oa [8];
  logic [31:0] od [8];
  logic clr = 0, e_seen = 0;
  int total = 0, bad = 0, wcnt = 0, re_cnt = 0, starts = 0, n = 0, both = 0;
  int cyc = 0, s_cyc = 0, e_cyc = 0, rc = 0, halt_after = 5;
  always #5 clk1 = ~clk1;
  mips_mem_loader #(.AW(AW), .DW(DW), .WDOG_CYCLES(WD)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .cpu_halted(halted), .dump_base(dump_base),
    .dump_len(dump_len), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done), .error(error));
  // Memory and core model; word 121 stands in for the program's result (130).
  always @(posedge clk1) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) rdata <= mem_addr == 10'd121 ? 32'd130 : mem[mem_addr];
    if (cpu_start) begin halted <= 0; rc <= 0; s_cyc <= cyc; end
    else begin rc <= rc + 1; if (halt_after != 0 && rc == halt_after) halted <= 1; end
    if (clr) begin wcnt <= 0; re_cnt <= 0; starts <= 0; n <= 0; both <= 0; e_seen <= 0; end
    else begin
      if (mem_we) begin if (wcnt < 16) wlog[wcnt] <= mem_addr; wcnt <= wcnt + 1; end
      if (mem_re) re_cnt <= re_cnt + 1;
      if (cpu_start) starts <= starts + 1;
      if (mem_we && mem_re) both <= both + 1;
      if (out_valid && out_ready) begin
        if (n < 8) begin oa[n] <= out_addr; od[n] <= out_data; end
        n <= n + 1;
      end
      if (error && !e_seen) begin e_seen <= 1; e_cyc <= cyc; end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s got=%0h exp=%0h", tag, got, exp); end
  endtask
  task automatic send(input logic [31:0] w, input bit gap);
    int k = 0;
    in_valid = 1; in_data = w;
    while (!in_ready && k < 50) begin @(negedge clk1); k++; end
    check("send_acc", 32'(k < 50), 1);
    @(negedge clk1);
    in_valid = 0;
    if (gap) @(negedge clk1);
  endtask
  task automatic load(input bit gap);
    send(32'h0008_0000, gap);
    for (int i = 0; i < 8; i++) send(PROG[i], gap);
    send(32'h0001_0078, gap);
    send(32'd85, gap);
    send(32'h0000_0000, gap);
  endtask
  task automatic do_reset();
    rst_n = 0; clr = 1; in_valid = 0; out_ready = 1;
    repeat (2) @(negedge clk1);
    rst_n = 1; clr = 0;
  endtask
  task automatic wait_done(input int b);
    int k = 0;
    while (!done && k < b) begin @(negedge clk1); k++; end
    check("done", 32'(done), 1);
  endtask
  task automatic wait_ov(input int b);
    int k = 0;
    while (!out_valid && k < b) begin @(negedge clk1); k++; end
    check("ov_seen", 32'(out_valid), 1);
  endtask
  task automatic check_dump();
    check("dump_n", n, 2);
    check("dump_a0", 32'(oa[0]), 120); check("dump_d0", od[0], 85);
    check("dump_a1", 32'(oa[1]), 121); check("dump_d1", od[1], 130);
  endtask
  task automatic check_mem();
    for (int i = 0; i < 8; i++) begin
      check("mem_prog", mem[i], PROG[i]);
      check("wlog", 32'(wlog[i]), i);
    end
    check("mem_120", mem[120], 85);
    check("wlog_120", 32'(wlog[8]), 120);
    check("wcnt", wcnt, 9);
  endtask
  initial begin
    #1 rst_n = 0; clr = 1;
    #12;
    check("rst_in_ready", 32'(in_ready), 0); check("rst_we", 32'(mem_we), 0);
    check("rst_re", 32'(mem_re), 0); check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0); check("rst_hold", 32'(cpu_hold), 1);
    check("rst_start", 32'(cpu_start), 0); check("rst_ov", 32'(out_valid), 0);
    check("rst_od", out_data, 0); check("rst_oa", 32'(out_addr), 0);
    check("rst_busy", 32'(busy), 0); check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    @(negedge clk1); rst_n = 1; clr = 0;
    // basic load, run, dump
    load(0);
    check("busy_run", 32'(busy), 1);
    wait_done(300);
    check_dump(); check_mem();
    check("starts", starts, 1); check("re_cnt", re_cnt, 2); check("we_re", both, 0);
    check("err_basic", 32'(error), 0); check("busy_done", 32'(busy), 0);
    check("hold_done", 32'(cpu_hold), 1);
    // output stall on first dump word
    do_reset(); out_ready = 0;
    load(0);
    wait_ov(300);
    check("stall_a", 32'(out_addr), 120); check("stall_d", out_data, 85);
    repeat (5) begin
      @(negedge clk1);
      check("stall_v", 32'(out_valid), 1); check("stall_a", 32'(out_addr), 120);
      check("stall_d", out_data, 85); check("stall_re", re_cnt, 1);
    end
    out_ready = 1;
    wait_done(100);
    check_dump(); check("stall_re_tot", re_cnt, 2);
    // bubbles on the load stream
    do_reset();
    load(1);
    wait_done(300);
    check_mem(); check_dump();
    // address wrap sets error, writes still happen
    do_reset(); dump_len = 0;
    send(32'h0003_03FF, 0); send(32'd11, 0); send(32'd22, 0); send(32'd33, 0);
    check("wrap_err", 32'(error), 1);
    send(32'h0, 0);
    wait_done(300);
    check("wrap_m3ff", mem[1023], 11); check("wrap_m0", mem[0], 22); check("wrap_m1", mem[1], 33);
    check("wrap_l0", 32'(wlog[0]), 1023); check("wrap_l1", 32'(wlog[1]), 0);
    check("wrap_l2", 32'(wlog[2]), 1);
    check("wrap_n", n, 0); check("wrap_re", re_cnt, 0);
    // reset during dump
    do_reset(); dump_len = 2; out_ready = 0;
    load(0);
    wait_ov(300);
    #2 rst_n = 0;
    #1;
    check("mid_ov", 32'(out_valid), 0); check("mid_hold", 32'(cpu_hold), 1);
    check("mid_re", 32'(mem_re), 0); check("mid_busy", 32'(busy), 0);
    check("mid_od", out_data, 0); check("mid_oa", 32'(out_addr), 0);
    @(negedge clk1);
    do_reset();
    load(0);
    wait_done(300);
    check_dump();
    // core never halts
    do_reset(); halt_after = 0;
    load(0);
`ifdef MIPS_LOADER_WDOG_EN
    begin
      int k = 0;
      while (!e_seen && k < 400) begin @(negedge clk1); k++; end
    end
    check("wdog_seen", 32'(e_seen), 1);
    check("wdog_lat", e_cyc - s_cyc, WD);
    wait_done(200);
    check_dump();
`else
    repeat (300) @(negedge clk1);
    check("hang_busy", 32'(busy), 1); check("hang_done", 32'(done), 0);
    check("hang_err", 32'(error), 0); check("hang_hold", 32'(cpu_hold), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
